// File: rtl/accel_frame_sequencer.sv
// Frame sequencer for an SPI accelerometer: one configuration write after reset,
// then periodic 5-byte read frames whose X/Y/Z bytes are published atomically.
module accel_frame_sequencer #(
    parameter int unsigned byte_delay    = 4,
    parameter int unsigned cs_setup      = 2,
    parameter int unsigned cs_gap        = 8,
    parameter int unsigned sample_period = 1000,
    parameter logic [7:0]  cmd_write     = 8'h0A,
    parameter logic [7:0]  cmd_read      = 8'h0B,
    parameter logic [7:0]  cfg_addr      = 8'h2D,
    parameter logic [7:0]  cfg_data      = 8'h02,
    parameter logic [7:0]  data_addr     = 8'h08
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    output logic       o_cs_n,
    output logic       o_tx_start,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_done,
    input  logic [7:0] i_rx_byte,
    output logic       o_busy,
    output logic       o_cfg_done,
    output logic [7:0] xSense,
    output logic [7:0] ySense,
    output logic [7:0] zSense,
    output logic       o_sample_valid
);
    localparam int SW = (cs_setup > 1) ? $clog2(cs_setup) : 1;
    localparam int DW = (byte_delay > 1) ? $clog2(byte_delay) : 1;
    localparam int PW = $clog2(sample_period + 1);
    localparam logic [SW-1:0] SETUP_LAST = SW'(cs_setup - 1);
    localparam logic [DW-1:0] DELAY_LAST = (byte_delay == 0) ? '0 : DW'(byte_delay - 1);
    localparam logic [PW-1:0] GAP_LEN    = PW'(cs_gap);
    localparam logic [PW-1:0] PERIOD     = PW'(sample_period);

    typedef enum logic [2:0] {
        CFG_SETUP, SETUP, SEND, WAIT_DONE, DELAY, GAP, IDLE
    } state_t;

    state_t          state_reg, state_next;
    logic            cs_n_reg, cs_n_next;
    logic            read_reg, read_next;
    logic [2:0]      idx_reg, idx_next;
    logic [SW-1:0]   setup_cnt_reg, setup_cnt_next;
    logic [DW-1:0]   dly_cnt_reg, dly_cnt_next;
    logic [PW-1:0]   per_cnt_reg, per_cnt_next;
    logic            cfg_done_reg, cfg_done_next;
    logic            valid_reg;
    logic            capture, frame_end, start_read, period_up;
    logic [2:0]      last_idx;
    logic [7:0]      cur_byte;
    logic [23:0]     sense_bus;

    assign last_idx  = read_reg ? 3'd4 : 3'd2;
    assign period_up = (per_cnt_reg >= PERIOD) && i_enable;

    always_comb begin
        cur_byte = 8'h00;
        if (read_reg) begin
            case (idx_reg)
                3'd0:    cur_byte = cmd_read;
                3'd1:    cur_byte = data_addr;
                default: cur_byte = 8'h00;
            endcase
        end else begin
            case (idx_reg)
                3'd0:    cur_byte = cmd_write;
                3'd1:    cur_byte = cfg_addr;
                3'd2:    cur_byte = cfg_data;
                default: cur_byte = 8'h00;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg     <= CFG_SETUP;
            cs_n_reg      <= 1'b1;
            read_reg      <= 1'b0;
            idx_reg       <= '0;
            setup_cnt_reg <= '0;
            dly_cnt_reg   <= '0;
            per_cnt_reg   <= '0;
            cfg_done_reg  <= 1'b0;
            valid_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cs_n_reg      <= cs_n_next;
            read_reg      <= read_next;
            idx_reg       <= idx_next;
            setup_cnt_reg <= setup_cnt_next;
            dly_cnt_reg   <= dly_cnt_next;
            per_cnt_reg   <= per_cnt_next;
            cfg_done_reg  <= cfg_done_next;
            valid_reg     <= frame_end && read_reg;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cs_n_next      = cs_n_reg;
        read_next      = read_reg;
        idx_next       = idx_reg;
        setup_cnt_next = setup_cnt_reg;
        dly_cnt_next   = dly_cnt_reg;
        per_cnt_next   = (per_cnt_reg < PERIOD) ? per_cnt_reg + 1'b1 : per_cnt_reg;
        cfg_done_next  = cfg_done_reg;
        capture        = 1'b0;
        frame_end      = 1'b0;
        start_read     = 1'b0;
        unique case (state_reg)
            // Setup time is counted only once CS is actually low, so the
            // post-reset cycle that drops CS is not part of it.
            CFG_SETUP, SETUP: begin
                cs_n_next = 1'b0;
                if (!cs_n_reg) begin
                    if (setup_cnt_reg == SETUP_LAST) begin
                        setup_cnt_next = '0;
                        state_next     = SEND;
                    end else begin
                        setup_cnt_next = setup_cnt_reg + 1'b1;
                    end
                end
            end
            SEND: state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (i_tx_done) begin
                    capture      = read_reg && (idx_reg >= 3'd2);
                    dly_cnt_next = '0;
                    state_next   = DELAY;
                end
            end
            DELAY: begin
                if (dly_cnt_reg == DELAY_LAST) begin
                    if (idx_reg == last_idx) begin
                        frame_end    = 1'b1;
                        cs_n_next    = 1'b1;
                        idx_next     = '0;
                        per_cnt_next = PW'(1);
                        if (!read_reg) cfg_done_next = 1'b1;
                        state_next   = GAP;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = SEND;
                    end
                end else begin
                    dly_cnt_next = dly_cnt_reg + 1'b1;
                end
            end
            // GAP may hand straight to SETUP when sample_period equals cs_gap.
            GAP: begin
                if (per_cnt_reg >= GAP_LEN) begin
                    if (period_up) start_read = 1'b1;
                    else           state_next = IDLE;
                end
            end
            IDLE:    if (period_up) start_read = 1'b1;
            default: state_next = CFG_SETUP;
        endcase
        if (start_read) begin
            state_next     = SETUP;
            cs_n_next      = 1'b0;
            read_next      = 1'b1;
            setup_cnt_next = '0;
        end
    end

    // Shadows fill during the frame; published outputs change only at CS release.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_axis
            logic [7:0] shadow_reg;
            logic [7:0] sense_reg;
            always_ff @(posedge i_clk or negedge i_rst) begin
                if (!i_rst) begin
                    shadow_reg <= '0;
                    sense_reg  <= '0;
                end else begin
                    if (capture && (idx_reg == 3'(gi + 2))) shadow_reg <= i_rx_byte;
                    if (frame_end && read_reg)              sense_reg  <= shadow_reg;
                end
            end
            assign sense_bus[8*gi +: 8] = sense_reg;
        end
    endgenerate

    assign o_cs_n         = cs_n_reg;
    assign o_busy         = ~cs_n_reg;
    assign o_tx_start     = (state_reg == SEND);
    assign o_tx_byte      = ((state_reg == SEND) || (state_reg == WAIT_DONE)) ? cur_byte : 8'h00;
    assign o_cfg_done     = cfg_done_reg;
    assign o_sample_valid = valid_reg;
    assign xSense         = sense_bus[7:0];
    assign ySense         = sense_bus[15:8];
    assign zSense         = sense_bus[23:16];
endmodule

// File: tb/tb_accel_frame_sequencer.sv
// Bench for accel_frame_sequencer: an engine model answers each byte start,
// a monitor logs frame events, and scenario tasks check them against timing rules.
`timescale 1ns/1ps
module tb_accel_frame_sequencer;
    localparam int CS_SETUP = 2;
    localparam int STEP     = 5;     // 4 idle cycles after done, then the start cycle
    localparam int STEP_B   = 3;     // byte_delay=0: start, wait, one delay cycle
    localparam int PERIOD   = 1000;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_enable = 1'b1;
    logic       i_tx_done = 1'b0;
    logic [7:0] i_rx_byte = 8'h00;
    logic       o_cs_n, o_tx_start, o_busy, o_cfg_done, o_sample_valid;
    logic [7:0] o_tx_byte, xSense, ySense, zSense;

    logic       rst_b = 1'b0;
    logic       b_tx_done = 1'b0;
    logic [7:0] b_rx = 8'h00;
    logic       b_cs_n, b_tx_start, b_busy, b_cfg_done, b_valid;
    logic [7:0] b_tx_byte, b_x, b_y, b_z;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    accel_frame_sequencer dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable),
        .o_cs_n(o_cs_n), .o_tx_start(o_tx_start), .o_tx_byte(o_tx_byte),
        .i_tx_done(i_tx_done), .i_rx_byte(i_rx_byte),
        .o_busy(o_busy), .o_cfg_done(o_cfg_done),
        .xSense(xSense), .ySense(ySense), .zSense(zSense),
        .o_sample_valid(o_sample_valid)
    );

    accel_frame_sequencer #(.byte_delay(0), .sample_period(40)) dut_b (
        .i_clk(i_clk), .i_rst(rst_b), .i_enable(1'b1),
        .o_cs_n(b_cs_n), .o_tx_start(b_tx_start), .o_tx_byte(b_tx_byte),
        .i_tx_done(b_tx_done), .i_rx_byte(b_rx),
        .o_busy(b_busy), .o_cfg_done(b_cfg_done),
        .xSense(b_x), .ySense(b_y), .zSense(b_z),
        .o_sample_valid(b_valid)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Event logs for the main DUT
    int         cs_fall_q[$], cs_rise_q[$], start_cyc_q[$], done_cyc_q[$], valid_cyc_q[$];
    logic [7:0] start_byte_q[$], rx_q[$];
    logic [23:0] valid_val_q[$];
    int         byte_glitch = 0;
    int         done_lat = 10;
    bit         spurious = 1'b0;
    bit         pend = 1'b0;
    bit         cs_prev = 1'b1;
    int         done_at = 0;
    logic [7:0] pend_byte = 8'h00;
    logic [7:0] rx_next = 8'h00;
    int         last_rise = 0;

    always @(negedge i_clk) begin
        if (i_rst) begin
            if (cs_prev && !o_cs_n) cs_fall_q.push_back(cyc);
            if (!cs_prev && o_cs_n) cs_rise_q.push_back(cyc);
            if (o_sample_valid) begin
                valid_cyc_q.push_back(cyc);
                valid_val_q.push_back({xSense, ySense, zSense});
            end
            if (pend && (o_tx_byte !== pend_byte)) byte_glitch++;
            if (o_tx_start) begin
                start_cyc_q.push_back(cyc);
                start_byte_q.push_back(o_tx_byte);
                pend      = 1'b1;
                pend_byte = o_tx_byte;
                done_at   = cyc + done_lat;
                rx_next   = (rx_q.size() > 0) ? rx_q.pop_front() : 8'($urandom);
            end
        end
        cs_prev   = o_cs_n;
        i_tx_done = 1'b0;
        if (!i_rst) begin
            pend = 1'b0;
        end else if (pend && (cyc == done_at)) begin
            i_tx_done = 1'b1;
            i_rx_byte = rx_next;
            pend      = 1'b0;
            done_cyc_q.push_back(cyc);
        end else if (spurious && !pend && ($urandom_range(0, 3) == 0)) begin
            i_tx_done = 1'b1;
            i_rx_byte = 8'($urandom);
        end
    end

    // Immediate-done engine for the byte_delay=0 instance
    int         b_start_q[$];
    logic [7:0] b_byte_q[$], b_rx_q[$];
    logic [23:0] b_val_q[$];
    bit         b_pend = 1'b0;

    always @(negedge i_clk) begin
        b_tx_done = b_pend;
        if (b_pend) begin
            b_rx = 8'($urandom);
            b_rx_q.push_back(b_rx);
        end
        b_pend = b_tx_start;
        if (b_tx_start) begin
            b_start_q.push_back(cyc);
            b_byte_q.push_back(b_tx_byte);
        end
        if (b_valid) b_val_q.push_back({b_x, b_y, b_z});
    end

    function automatic logic [7:0] exp_byte(input bit rd, input int i);
        if (rd) return (i == 0) ? 8'h0B : (i == 1) ? 8'h08 : 8'h00;
        return (i == 0) ? 8'h0A : (i == 1) ? 8'h2D : 8'h02;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic clear_logs();
        cs_fall_q.delete(); cs_rise_q.delete(); start_cyc_q.delete();
        done_cyc_q.delete(); valid_cyc_q.delete(); start_byte_q.delete();
        valid_val_q.delete();
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        repeat (3) tick();
        checks++; if (o_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got=%b want=1", o_cs_n); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", o_busy); end
        checks++; if (o_tx_start !== 1'b0 || o_tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx got=%b/%h want=0/00", o_tx_start, o_tx_byte); end
        checks++; if (o_cfg_done !== 1'b0 || o_sample_valid !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b want=00", o_cfg_done, o_sample_valid); end
        checks++; if ({xSense, ySense, zSense} !== 24'h0) begin errors++; $display("FAIL reset_sense got=%h want=000000", {xSense, ySense, zSense}); end
        clear_logs();
        i_rst = 1'b1;
        $display("reset released at cycle %0d", cyc);
    endtask

    task automatic test_config();
        int n = 0;
        while (cs_rise_q.size() == 0 && n < 300) begin tick(); n++; end
        checks++;
        if (cs_rise_q.size() == 0 || start_cyc_q.size() != 3 || done_cyc_q.size() != 3 || cs_fall_q.size() != 1) begin
            errors++;
            $display("FAIL cfg_frame_shape rises=%0d starts=%0d dones=%0d falls=%0d want 1/3/3/1",
                     cs_rise_q.size(), start_cyc_q.size(), done_cyc_q.size(), cs_fall_q.size());
        end else begin
            checks++; if (start_cyc_q[0] != cs_fall_q[0] + CS_SETUP) begin errors++; $display("FAIL cfg_setup got=%0d want=%0d", start_cyc_q[0], cs_fall_q[0] + CS_SETUP); end
            for (int i = 0; i < 3; i++) begin
                checks++; if (start_byte_q[i] !== exp_byte(1'b0, i)) begin errors++; $display("FAIL cfg_byte%0d got=%h want=%h", i, start_byte_q[i], exp_byte(1'b0, i)); end
            end
            for (int i = 1; i < 3; i++) begin
                checks++; if (start_cyc_q[i] != done_cyc_q[i-1] + STEP) begin errors++; $display("FAIL cfg_gap%0d got=%0d want=%0d", i, start_cyc_q[i], done_cyc_q[i-1] + STEP); end
            end
            checks++; if (cs_rise_q[0] != done_cyc_q[2] + STEP) begin errors++; $display("FAIL cfg_cs_rise got=%0d want=%0d", cs_rise_q[0], done_cyc_q[2] + STEP); end
            last_rise = cs_rise_q[0];
        end
        checks++; if (o_cfg_done !== 1'b1) begin errors++; $display("FAIL cfg_done got=%b want=1", o_cfg_done); end
        checks++; if (valid_cyc_q.size() != 0) begin errors++; $display("FAIL cfg_no_valid got=%0d pulses want=0", valid_cyc_q.size()); end
        checks++; if (byte_glitch != 0) begin errors++; $display("FAIL cfg_byte_stable got=%0d glitches want=0", byte_glitch); end
        $display("config frame ended at cycle %0d", last_rise);
    endtask

    task automatic test_read_frames();
        logic [7:0] rx [5];
        for (int f = 0; f < 4; f++) begin
            int n = 0;
            clear_logs();
            done_lat = (f == 0) ? 10 : int'($urandom_range(1, 12));
            for (int i = 0; i < 5; i++) rx[i] = 8'($urandom);
            if (f == 0) begin rx[2] = 8'h11; rx[3] = 8'h22; rx[4] = 8'h33; end
            for (int i = 0; i < 5; i++) rx_q.push_back(rx[i]);
            while (valid_cyc_q.size() == 0 && n < 1300) begin tick(); n++; end
            checks++;
            if (valid_cyc_q.size() == 0 || start_cyc_q.size() != 5 || done_cyc_q.size() != 5 ||
                cs_fall_q.size() != 1 || cs_rise_q.size() != 1) begin
                errors++;
                $display("FAIL rd%0d_shape valids=%0d starts=%0d dones=%0d falls=%0d rises=%0d want 1/5/5/1/1",
                         f, valid_cyc_q.size(), start_cyc_q.size(), done_cyc_q.size(), cs_fall_q.size(), cs_rise_q.size());
            end else begin
                checks++; if (cs_fall_q[0] != last_rise + PERIOD) begin errors++; $display("FAIL rd%0d_period got=%0d want=%0d", f, cs_fall_q[0], last_rise + PERIOD); end
                checks++; if (start_cyc_q[0] != cs_fall_q[0] + CS_SETUP) begin errors++; $display("FAIL rd%0d_setup got=%0d want=%0d", f, start_cyc_q[0], cs_fall_q[0] + CS_SETUP); end
                for (int i = 0; i < 5; i++) begin
                    checks++; if (start_byte_q[i] !== exp_byte(1'b1, i)) begin errors++; $display("FAIL rd%0d_byte%0d got=%h want=%h", f, i, start_byte_q[i], exp_byte(1'b1, i)); end
                    if (i > 0) begin
                        checks++; if (start_cyc_q[i] != done_cyc_q[i-1] + STEP) begin errors++; $display("FAIL rd%0d_gap%0d got=%0d want=%0d", f, i, start_cyc_q[i], done_cyc_q[i-1] + STEP); end
                    end
                end
                checks++; if (cs_rise_q[0] != done_cyc_q[4] + STEP) begin errors++; $display("FAIL rd%0d_cs_rise got=%0d want=%0d", f, cs_rise_q[0], done_cyc_q[4] + STEP); end
                checks++; if (valid_cyc_q[0] != cs_rise_q[0]) begin errors++; $display("FAIL rd%0d_valid_at got=%0d want=%0d", f, valid_cyc_q[0], cs_rise_q[0]); end
                checks++; if (valid_val_q[0] !== {rx[2], rx[3], rx[4]}) begin errors++; $display("FAIL rd%0d_xyz got=%h want=%h", f, valid_val_q[0], {rx[2], rx[3], rx[4]}); end
                last_rise = cs_rise_q[0];
            end
            checks++; if (o_sample_valid !== 1'b0 || valid_cyc_q.size() > 1) begin errors++; $display("FAIL rd%0d_single_pulse got=%b/%0d want=0/1", f, o_sample_valid, valid_cyc_q.size()); end
            checks++; if ({xSense, ySense, zSense} !== {rx[2], rx[3], rx[4]}) begin errors++; $display("FAIL rd%0d_hold got=%h want=%h", f, {xSense, ySense, zSense}, {rx[2], rx[3], rx[4]}); end
            $display("read frame %0d lat=%0d xyz=%h", f, done_lat, {xSense, ySense, zSense});
        end
        checks++; if (byte_glitch != 0) begin errors++; $display("FAIL rd_byte_stable got=%0d glitches want=0", byte_glitch); end
    endtask

    task automatic test_enable_low();
        logic [23:0] held;
        logic [7:0]  rx [5];
        int x, n;
        held = {xSense, ySense, zSense};
        i_enable = 1'b0;
        spurious = 1'b1;
        clear_logs();
        while (cyc < last_rise + PERIOD + 150) tick();
        spurious = 1'b0;
        checks++; if (cs_fall_q.size() != 0 || start_cyc_q.size() != 0 || o_cs_n !== 1'b1) begin errors++; $display("FAIL en_low_idle falls=%0d starts=%0d cs_n=%b want 0/0/1", cs_fall_q.size(), start_cyc_q.size(), o_cs_n); end
        checks++; if (valid_cyc_q.size() != 0 || {xSense, ySense, zSense} !== held) begin errors++; $display("FAIL en_low_sense got=%h/%0d want=%h/0", {xSense, ySense, zSense}, valid_cyc_q.size(), held); end
        tick(); tick();
        for (int i = 0; i < 5; i++) begin rx[i] = 8'($urandom); rx_q.push_back(rx[i]); end
        done_lat = 4;
        x = cyc;
        i_enable = 1'b1;
        tick(); tick();
        checks++;
        if (cs_fall_q.size() != 1) begin errors++; $display("FAIL en_rise_fall got=%0d falls want=1", cs_fall_q.size()); end
        else if (cs_fall_q[0] != x + 1) begin errors++; $display("FAIL en_rise_fall got=%0d want=%0d", cs_fall_q[0], x + 1); end
        n = 0;
        while (start_cyc_q.size() == 0 && n < 20) begin tick(); n++; end
        i_enable = 1'b0;
        n = 0;
        while (valid_cyc_q.size() == 0 && n < 200) begin tick(); n++; end
        checks++;
        if (valid_cyc_q.size() != 1 || cs_rise_q.size() != 1) begin errors++; $display("FAIL en_fall_frame got=%0d valids want=1", valid_cyc_q.size()); end
        else begin
            checks++; if (valid_val_q[0] !== {rx[2], rx[3], rx[4]}) begin errors++; $display("FAIL en_fall_xyz got=%h want=%h", valid_val_q[0], {rx[2], rx[3], rx[4]}); end
            last_rise = cs_rise_q[0];
        end
        i_enable = 1'b1;
        $display("enable-low scenario done, xyz=%h", {xSense, ySense, zSense});
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_logs();
        for (int i = 0; i < 5; i++) rx_q.push_back(8'($urandom_range(1, 255)));
        done_lat = int'($urandom_range(2, 8));
        while (done_cyc_q.size() < 4 && n < 1300) begin tick(); n++; end
        @(posedge i_clk);
        #3;
        i_rst = 1'b0;
        #1;
        checks++; if (done_cyc_q.size() != 4) begin errors++; $display("FAIL rm_reach_y got=%0d dones want=4", done_cyc_q.size()); end
        checks++; if (o_cs_n !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL rm_cs_async got=%b/%b want=1/0", o_cs_n, o_busy); end
        checks++; if ({xSense, ySense, zSense} !== 24'h0 || o_cfg_done !== 1'b0) begin errors++; $display("FAIL rm_clear got=%h/%b want=000000/0", {xSense, ySense, zSense}, o_cfg_done); end
        repeat (3) tick();
        checks++; if (valid_cyc_q.size() != 0) begin errors++; $display("FAIL rm_no_valid got=%0d want=0", valid_cyc_q.size()); end
        clear_logs();
        rx_q.delete();
        i_rst = 1'b1;
        n = 0;
        while (cs_rise_q.size() == 0 && n < 300) begin tick(); n++; end
        checks++;
        if (start_cyc_q.size() != 3 || cs_fall_q.size() != 1) begin errors++; $display("FAIL rm_cfg_shape starts=%0d falls=%0d want 3/1", start_cyc_q.size(), cs_fall_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (start_byte_q[i] !== exp_byte(1'b0, i)) begin errors++; $display("FAIL rm_cfg_byte%0d got=%h want=%h", i, start_byte_q[i], exp_byte(1'b0, i)); end
            end
            checks++; if (start_cyc_q[0] != cs_fall_q[0] + CS_SETUP) begin errors++; $display("FAIL rm_cfg_setup got=%0d want=%0d", start_cyc_q[0], cs_fall_q[0] + CS_SETUP); end
        end
        checks++; if (o_cfg_done !== 1'b1 || valid_cyc_q.size() != 0 || {xSense, ySense, zSense} !== 24'h0) begin errors++; $display("FAIL rm_after got=%b/%0d/%h want=1/0/000000", o_cfg_done, valid_cyc_q.size(), {xSense, ySense, zSense}); end
        $display("mid-frame reset scenario done at cycle %0d", cyc);
    endtask

    task automatic test_byte_delay_zero();
        int n = 0;
        while (b_val_q.size() < 3 && n < 1000) begin tick(); n++; end
        checks++;
        if (b_val_q.size() < 3 || b_start_q.size() < 18 || b_rx_q.size() < 18) begin
            errors++;
            $display("FAIL bd0_shape valids=%0d starts=%0d rx=%0d want >=3/18/18", b_val_q.size(), b_start_q.size(), b_rx_q.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++; if (b_start_q[i] - b_start_q[i-1] != STEP_B) begin errors++; $display("FAIL bd0_cfg_gap%0d got=%0d want=%0d", i, b_start_q[i] - b_start_q[i-1], STEP_B); end
            end
            for (int k = 0; k < 3; k++) begin
                int base = 3 + 5 * k;
                checks++; if (b_byte_q[base] !== 8'h0B || b_byte_q[base+1] !== 8'h08) begin errors++; $display("FAIL bd0_rd%0d_hdr got=%h%h want=0B08", k, b_byte_q[base], b_byte_q[base+1]); end
                for (int i = 1; i < 5; i++) begin
                    checks++; if (b_start_q[base+i] - b_start_q[base+i-1] != STEP_B) begin errors++; $display("FAIL bd0_rd%0d_gap%0d got=%0d want=%0d", k, i, b_start_q[base+i] - b_start_q[base+i-1], STEP_B); end
                end
                checks++; if (b_val_q[k] !== {b_rx_q[base+2], b_rx_q[base+3], b_rx_q[base+4]}) begin errors++; $display("FAIL bd0_rd%0d_xyz got=%h want=%h", k, b_val_q[k], {b_rx_q[base+2], b_rx_q[base+3], b_rx_q[base+4]}); end
                $display("bd0 read frame %0d xyz=%h", k, b_val_q[k]);
            end
        end
        checks++; if (b_cfg_done !== 1'b1 || b_busy !== ~b_cs_n) begin errors++; $display("FAIL bd0_flags got=%b/%b/%b want cfg=1 busy=~cs_n", b_cfg_done, b_busy, b_cs_n); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        rst_b = 1'b1;
        test_reset();
        test_config();
        test_read_frames();
        test_enable_low();
        test_reset_mid();
        test_byte_delay_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
